pll_cfg_lock_ctrl: RTL

Parametrised configuration and lock-supervision controller for the analog PLL macro.
- Accepts divider settings over a valid/ready handshake and drives the PLL DIVF/DIVR/DIVQ/BYPASS/RESET pins.
- Sequences the PLL reset and measures FB-vs-REF frequency digitally.
- Raises LOCK itself, rather than relying on the macro's raw lock pin, and adds loss-of-lock detection and acquisition retry.

---
 rtl/pll_cfg_lock_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_cfg_lock_ctrl.sv
// pll_cfg_lock_ctrl
// Configuration and lock-supervision controller for the analog PLL macro.
// Divider settings arrive over a valid/ready handshake and are driven onto the
// PLL pins. After each non-bypass config the PLL reset is sequenced, then the
// FB tick rate is measured against REF in windows of DIVR+1 REF ticks. LOCK is
// raised after LOCK_WINDOWS consecutive good windows. A bad window while
// locked drops LOCK and sets the sticky LOCK_LOST flag. MAX_WINDOWS windows
// without lock trigger a RETRY pulse and a fresh PLL reset.
//
// Handshake: a configuration transfers on a rising CK edge where CFG_VALID and
// CFG_READY are both high. The requester holds CFG_VALID and the CFG_* payload
// stable until that edge. CFG_READY is registered and never depends on
// CFG_VALID in the same cycle.
module pll_cfg_lock_ctrl #(
    parameter int DIVF_W       = 8,
    parameter int DIVR_W       = 6,
    parameter int DIVQ_W       = 3,
    parameter int RESET_CYC    = 16,
    parameter int LOCK_WINDOWS = 4,
    parameter int TOL          = 2,
    parameter int MAX_WINDOWS  = 64
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [DIVF_W-1:0] CFG_DIVF,
    input  logic [DIVR_W-1:0] CFG_DIVR,
    input  logic [DIVQ_W-1:0] CFG_DIVQ,
    input  logic              CFG_BYPASS,
    input  logic              REF_TICK,
    input  logic              FB_TICK,
    output logic              PLL_RESET,
    output logic [DIVF_W-1:0] DIVF,
    output logic [DIVR_W-1:0] DIVR,
    output logic [DIVQ_W-1:0] DIVQ,
    output logic              BYPASS,
    output logic              LOCK,
    output logic              LOCK_LOST,
    output logic              RETRY,
    output logic [2:0]        DBG_STATE
);

    // FB counter is two bits wider than DIVF so that overshoot is visible
    // before it saturates.
    localparam int FB_W   = DIVF_W + 2;
    localparam int RST_CW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
    localparam int GOOD_W = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;
    localparam int WIN_W  = (MAX_WINDOWS > 0) ? $clog2(MAX_WINDOWS + 1) : 1;

    localparam logic [FB_W-1:0]   FB_MAX     = '1;
    localparam logic [RST_CW-1:0] RST_LAST   = RST_CW'(RESET_CYC - 1);
    localparam logic [GOOD_W-1:0] GOOD_LIMIT = GOOD_W'(LOCK_WINDOWS);
    localparam logic [WIN_W-1:0]  WIN_LIMIT  = WIN_W'(MAX_WINDOWS);
    localparam logic [FB_W-1:0]   FB_TOL     = FB_W'(TOL);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_ACQ    = 3'd2,
        S_LOCKED = 3'd3,
        S_BYP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                pll_reset_q, pll_reset_d;
    logic [DIVF_W-1:0]   divf_q, divf_d;
    logic [DIVR_W-1:0]   divr_q, divr_d;
    logic [DIVQ_W-1:0]   divq_q, divq_d;
    logic                bypass_q, bypass_d;
    logic                lock_q, lock_d;
    logic                lock_lost_q, lock_lost_d;
    logic                retry_q, retry_d;
    logic [RST_CW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [DIVR_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [FB_W-1:0]     fb_cnt_q, fb_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;

    // Window measurement results for the current cycle.
    logic                accept;
    logic                win_close;
    logic                win_good;
    logic [FB_W-1:0]     fb_inc;
    logic [FB_W-1:0]     fb_exp;
    logic [FB_W-1:0]     fb_err;
    logic [DIVR_W-1:0]   meas_ref_d;
    logic [FB_W-1:0]     meas_fb_d;
    logic [GOOD_W-1:0]   good_inc;
    logic [WIN_W-1:0]    win_inc;

    assign accept = CFG_VALID && cfg_ready_q;

    // Window measurement: count FB ticks (saturating), detect the closing REF
    // tick, and grade the finished window against DIVF+1 within TOL.
    always_comb begin
        fb_inc = fb_cnt_q;
        if (FB_TICK && (fb_cnt_q != FB_MAX)) begin
            fb_inc = fb_cnt_q + FB_W'(1);
        end
        win_close = REF_TICK && (ref_cnt_q == divr_q);
        fb_exp    = FB_W'(divf_q) + FB_W'(1);
        if (fb_inc >= fb_exp) begin
            fb_err = fb_inc - fb_exp;
        end else begin
            fb_err = fb_exp - fb_inc;
        end
        win_good = (fb_err <= FB_TOL);

        // A closing tick restarts both counters; the FB tick on that same
        // cycle already went into the window being graded.
        meas_ref_d = ref_cnt_q;
        meas_fb_d  = fb_inc;
        if (REF_TICK) begin
            if (win_close) begin
                meas_ref_d = '0;
                meas_fb_d  = '0;
            end else begin
                meas_ref_d = ref_cnt_q + DIVR_W'(1);
            end
        end

        good_inc = good_cnt_q + GOOD_W'(1);
        win_inc  = win_cnt_q + WIN_W'(1);
    end

    // Next-state and output decode for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        pll_reset_d = pll_reset_q;
        divf_d      = divf_q;
        divr_d      = divr_q;
        divq_d      = divq_q;
        bypass_d    = bypass_q;
        lock_d      = lock_q;
        lock_lost_d = lock_lost_q;
        retry_d     = 1'b0;
        rst_cnt_d   = rst_cnt_q;
        ref_cnt_d   = ref_cnt_q;
        fb_cnt_d    = fb_cnt_q;
        good_cnt_d  = good_cnt_q;
        win_cnt_d   = win_cnt_q;

        case (state_q)
            S_IDLE: begin
                pll_reset_d = 1'b1;
                lock_d      = 1'b0;
            end

            S_BYP: begin
                pll_reset_d = 1'b1;
                lock_d      = 1'b1;
            end

            S_RST: begin
                pll_reset_d = 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    pll_reset_d = 1'b0;
                    state_d     = S_ACQ;
                    ref_cnt_d   = '0;
                    fb_cnt_d    = '0;
                    good_cnt_d  = '0;
                    win_cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CW'(1);
                end
            end

            S_ACQ: begin
                ref_cnt_d = meas_ref_d;
                fb_cnt_d  = meas_fb_d;
                if (win_close) begin
                    win_cnt_d = win_inc;
                    if (win_good) begin
                        good_cnt_d = good_inc;
                    end else begin
                        good_cnt_d = '0;
                    end
                    if (win_good && (good_inc == GOOD_LIMIT)) begin
                        state_d = S_LOCKED;
                        lock_d  = 1'b1;
                    end else if (win_inc == WIN_LIMIT) begin
                        // Acquisition timed out: pulse RETRY and re-run reset.
                        retry_d     = 1'b1;
                        state_d     = S_RST;
                        pll_reset_d = 1'b1;
                        rst_cnt_d   = '0;
                    end
                end
            end

            S_LOCKED: begin
                ref_cnt_d = meas_ref_d;
                fb_cnt_d  = meas_fb_d;
                if (win_close && !win_good) begin
                    state_d     = S_ACQ;
                    lock_d      = 1'b0;
                    lock_lost_d = 1'b1;
                    good_cnt_d  = '0;
                    win_cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted configuration overrides whatever the window logic chose.
        if (accept) begin
            divf_d      = CFG_DIVF;
            divr_d      = CFG_DIVR;
            divq_d      = CFG_DIVQ;
            bypass_d    = CFG_BYPASS;
            lock_d      = 1'b0;
            lock_lost_d = 1'b0;
            retry_d     = 1'b0;
            pll_reset_d = 1'b1;
            rst_cnt_d   = '0;
            state_d     = CFG_BYPASS ? S_BYP : S_RST;
        end

        cfg_ready_d = (state_d == S_IDLE) || (state_d == S_LOCKED) ||
                      (state_d == S_BYP);
    end

    // State and output registers; reset forces the safe PLL-held-in-reset values.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            pll_reset_q <= 1'b1;
            divf_q      <= '0;
            divr_q      <= '0;
            divq_q      <= '0;
            bypass_q    <= 1'b0;
            lock_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= 1'b0;
            rst_cnt_q   <= '0;
            ref_cnt_q   <= '0;
            fb_cnt_q    <= '0;
            good_cnt_q  <= '0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            pll_reset_q <= pll_reset_d;
            divf_q      <= divf_d;
            divr_q      <= divr_d;
            divq_q      <= divq_d;
            bypass_q    <= bypass_d;
            lock_q      <= lock_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
            rst_cnt_q   <= rst_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            fb_cnt_q    <= fb_cnt_d;
            good_cnt_q  <= good_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    assign CFG_READY = cfg_ready_q;
    assign PLL_RESET = pll_reset_q;
    assign DIVF      = divf_q;
    assign DIVR      = divr_q;
    assign DIVQ      = divq_q;
    assign BYPASS    = bypass_q;
    assign LOCK      = lock_q;
    assign LOCK_LOST = lock_lost_q;
    assign RETRY     = retry_q;
    assign DBG_STATE = state_q;

endmodule
